pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and fetch-control stage sitting directly upstream of the instruction ROM in the single-cycle MIPS core. It holds the architectural PC, drives it to the ROM, and picks the next PC from the sequential, branch (beq) and jump paths. It gates the returned instruction toward decode with a valid flag and a stall hold. It also detects an out-of-range PC or halt request, parks the core in a halted state, and keeps a retired-instruction counter.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; must be word-aligned.
- ROM_WORDS, 16, number of valid 32-bit ROM words; legal PCs are 0 .. ROM_WORDS*4-4.

Ports:
- clk  in  1  single core clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- stall  in  1  decode/execute cannot accept; hold PC and current instruction.
- branch_taken  in  1  beq resolved taken this cycle.
- branch_offset  in  16  signed word offset from the beq immediate.
- jump  in  1  j instruction this cycle.
- jump_target  in  26  j instruction index field.
- halt_req  in  1  request to stop fetching.
- rom_instr  in  32  instruction returned combinationally by the ROM for pc.
- pc  out  32  current PC, drives ROM address.
- pc_plus4  out  32  pc + 4, for link/branch use downstream.
- instr  out  32  instruction to decode; 32'h0 when instr_valid=0.
- instr_valid  out  1  instr is a real instruction to execute this cycle.
- halted  out  1  core stopped; only reset exits.
- instr_count  out  32  instructions retired since reset.

## Operation
- States: BOOT, RUN, HALT.
- BOOT: entered on reset; instr_valid=0; pc held. Next cycle goes to RUN unconditionally, unless halt_req=1, which goes to HALT.
- RUN: instr_valid=1, instr=rom_instr.
- An instruction retires on a cycle where instr_valid=1 and stall=0. On retirement, pc loads next_pc and instr_count increments by 1.
- next_pc priority: jump > branch_taken > sequential.
  - jump: {pc_plus4[31:28], jump_target, 2'b00}.
  - branch: pc_plus4 + (sign-extend(branch_offset) << 2), 32-bit modulo.
  - sequential: pc_plus4, 32-bit modulo; 0xFFFF_FFFC wraps to 0.
- stall=1 in RUN: pc, instr and instr_count are held; jump, branch_taken and halt_req are ignored that cycle.
- RUN to HALT happens at a retiring edge when either:
  - halt_req=1 (the current instruction still retires and counts), or
  - next_pc[31:2] >= ROM_WORDS (out of range). The current instruction retires and counts, pc is NOT updated, and the core halts.
- HALT: instr_valid=0, instr=0, halted=1, pc and instr_count frozen; all inputs ignored.
- rst_n=0 in any state, including mid-stall or in HALT: on that edge state returns to BOOT and all registers take their reset values.

## Timing
- Reset values after an edge with rst_n=0: pc=RESET_PC, pc_plus4=RESET_PC+4, instr=0, instr_valid=0, halted=0, instr_count=0, state=BOOT.
- pc, pc_plus4, halted and instr_count are registered outputs.
- instr and instr_valid are combinational from state and rom_instr: zero registered latency, since ROM read is combinational.
- First valid instruction appears in the cycle after reset is released (the BOOT cycle is one bubble).
- A redirect (branch/jump) takes effect at the next edge: the target instruction is valid in the following cycle, with no bubble.
- halted rises on the edge that retires the last instruction; instr_valid is 0 from the next cycle onward.

## Test plan
- Reset/boot: hold rst_n=0 for 2 cycles, then release -> pc=0, instr_valid=0 for one cycle; then instr_valid=1, instr=ROM[0]; count=1 after the next edge.
- Sequential plus stall: run 3 instructions with stall=1 for 2 cycles on pc=4 -> pc stays 4, instr stays ROM[1], count frozen at 1 during the stall; pc=8 after the stall releases.
- Branch: at pc=0x10, branch_taken=1, offset=+1 -> pc=0x18; offset=16'hFFFE -> pc=0x0C; with jump=1 asserted simultaneously -> jump target wins.
- Jump: jump=1, jump_target=26'h3 at pc=0 -> pc=0x0C on the next edge, instr_valid stays 1.
- Range fault: ROM_WORDS=16, sequential at pc=0x3C -> instruction counted, pc stays 0x3C, halted=1, instr_valid=0; later stimulus has no effect.
- Halt and reset: halt_req=1 during stall -> ignored; halt_req=1 unstalled -> HALT. Then assert rst_n=0 -> pc=RESET_PC, count=0, halted=0, BOOT.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle between the PC/fetch control block and its neighbours.
// The fetch block takes the slave view: it consumes control inputs and the ROM
// word, and produces the PC, the gated instruction and the status outputs.
interface pc_fetch_if;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        halt_req;
    logic [31:0] rom_instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        halted;
    logic [31:0] instr_count;

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_target, halt_req, rom_instr,
        input  pc, pc_plus4, instr, instr_valid, halted, instr_count
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_target, halt_req, rom_instr,
        output pc, pc_plus4, instr, instr_valid, halted, instr_count
    );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and fetch control for the single-cycle MIPS core.
// Holds the PC, selects next PC (jump > branch > sequential), gates the ROM
// word toward decode, halts on request or out-of-range PC, counts retirements.
module pc_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 16
) (
    input logic   clk,
    input logic   rst_n,
    pc_fetch_if.slave bus
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    localparam logic [29:0] ROM_LIMIT = 30'(ROM_WORDS);

    state_t      state, state_next;
    logic [31:0] pc_q, pc_plus4_q, count_q;
    logic        halted_q;
    logic [31:0] next_pc, branch_pc, jump_pc;
    logic        out_of_range;
    logic        retire;
    logic [31:0] instr_d;
    logic        valid_d;

    // Next-PC selection and range check of the selected target.
    always_comb begin
        branch_pc = pc_plus4_q + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
        jump_pc   = {pc_plus4_q[31:28], bus.jump_target, 2'b00};
        if (bus.jump) begin
            next_pc = jump_pc;
        end else if (bus.branch_taken) begin
            next_pc = branch_pc;
        end else begin
            next_pc = pc_plus4_q;
        end
        out_of_range = (next_pc[31:2] >= ROM_LIMIT);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next state, retirement strobe and decode-facing instruction gating.
    always_comb begin
        state_next = state;
        valid_d    = 1'b0;
        instr_d    = '0;
        retire     = 1'b0;
        unique case (state)
            BOOT: begin
                state_next = bus.halt_req ? HALT : RUN;
            end
            RUN: begin
                valid_d = 1'b1;
                instr_d = bus.rom_instr;
                if (!bus.stall) begin
                    retire = 1'b1;
                    if (bus.halt_req || out_of_range) begin
                        state_next = HALT;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // PC, PC+4, retirement counter and halted flag; an out-of-range target
    // still retires the current instruction but leaves the PC in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC + 32'd4;
            count_q    <= '0;
            halted_q   <= 1'b0;
        end else begin
            if (retire) begin
                count_q <= count_q + 32'd1;
                if (!out_of_range) begin
                    pc_q       <= next_pc;
                    pc_plus4_q <= next_pc + 32'd4;
                end
            end
            halted_q <= (state_next == HALT);
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4_q;
    assign bus.instr       = instr_d;
    assign bus.instr_valid = valid_d;
    assign bus.halted      = halted_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: a directed vector table for the boot, stall,
// redirect, range-fault and halt/reset corners, then randomized traffic
// checked against an architectural model of the fetch stage.
module tb_pc_fetch;

    localparam int unsigned ROM_WORDS = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] rom [ROM_WORDS];

    int ncmp  = 0;
    int nfail = 0;

    pc_fetch_if bus ();

    pc_fetch #(
        .RESET_PC (32'h0000_0000),
        .ROM_WORDS(ROM_WORDS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.rom_instr = rom[bus.pc[5:2]];

    // Architectural model: PC, retired count, halted, and a pending boot bubble.
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        m_halted;
    logic        m_boot;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [15:0] off;
        logic        jmp;
        logic [25:0] jt;
        logic        halt;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ecnt;
        logic        eh;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t v(input logic r, input logic s, input logic b, input logic [15:0] o,
                               input logic j, input logic [25:0] t, input logic h,
                               input logic ev, input logic [31:0] epc, input logic [31:0] ecnt,
                               input logic eh);
        vec_t x;
        x.rst = r; x.stall = s; x.br = b; x.off = o; x.jmp = j; x.jt = t; x.halt = h;
        x.ev = ev; x.epc = epc; x.ecnt = ecnt; x.eh = eh;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input logic r, input logic s, input logic b,
                                       input logic [15:0] o, input logic j,
                                       input logic [25:0] t, input logic h);
        logic [31:0] target;
        if (!r) begin
            m_pc = 32'h0; m_count = 0; m_halted = 1'b0; m_boot = 1'b1;
        end else if (m_halted) begin
            // frozen until reset
        end else if (m_boot) begin
            m_boot = 1'b0;
            if (h) m_halted = 1'b1;
        end else if (!s) begin
            m_count = m_count + 1;
            if (j)
                target = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(t) * 32'd4);
            else if (b)
                target = m_pc + 32'd4 + 32'(int'($signed(o)) * 4);
            else
                target = m_pc + 32'd4;
            if (h || (target >> 2) >= ROM_WORDS) m_halted = 1'b1;
            if ((target >> 2) < ROM_WORDS) m_pc = target;
        end
    endfunction

    // Drive one cycle of inputs, sample the combinational outputs before the
    // edge, then return one time unit after the edge for registered checks.
    task automatic cycle(input logic r, input logic s, input logic b, input logic [15:0] o,
                         input logic j, input logic [25:0] t, input logic h,
                         output logic got_v, output logic [31:0] got_i);
        rst_n = r;
        bus.stall = s; bus.branch_taken = b; bus.branch_offset = o;
        bus.jump = j; bus.jump_target = t; bus.halt_req = h;
        #1;
        got_v = bus.instr_valid;
        got_i = bus.instr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        gv;
        logic [31:0] gi;
        logic [31:0] prev_pc;
        logic        mv;
        logic [31:0] mi;
        logic        r, s, b, j, h;
        logic [15:0] o;
        logic [25:0] t;

        for (int i = 0; i < int'(ROM_WORDS); i++) rom[i] = 32'hA500_0000 + 32'(i) * 32'h0101_0111;

        rst_n = 1'b0;
        bus.stall = 0; bus.branch_taken = 0; bus.branch_offset = '0;
        bus.jump = 0; bus.jump_target = '0; bus.halt_req = 0;
        @(posedge clk);
        #1;
        model_step(1'b0, 0, 0, '0, 0, '0, 0);

        //            rst s  b  off       j  jt     h    ev epc       cnt eh
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 26'h0, 0,   0, 32'h00, 0, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 26'h0, 0,   0, 32'h00, 0, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 26'h0, 0,   1, 32'h04, 1, 0));
        tbl.push_back(v(1, 1, 0, 16'h0000, 0, 26'h0, 0,   1, 32'h04, 1, 0));
        tbl.push_back(v(1, 1, 0, 16'h0000, 1, 26'h9, 1,   1, 32'h04, 1, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 26'h0, 0,   1, 32'h08, 2, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 26'h0, 0,   1, 32'h0C, 3, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 26'h0, 0,   1, 32'h10, 4, 0));
        tbl.push_back(v(1, 0, 1, 16'h0001, 0, 26'h0, 0,   1, 32'h18, 5, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 1, 26'h4, 0,   1, 32'h10, 6, 0));
        tbl.push_back(v(1, 0, 1, 16'hFFFE, 0, 26'h0, 0,   1, 32'h0C, 7, 0));
        tbl.push_back(v(1, 0, 1, 16'h0001, 1, 26'h2, 0,   1, 32'h08, 8, 0));
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 26'h0, 0,   1, 32'h00, 0, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 26'h0, 0,   0, 32'h00, 0, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 1, 26'h3, 0,   1, 32'h0C, 1, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 26'h0, 0,   1, 32'h10, 2, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 1, 26'hF, 0,   1, 32'h3C, 3, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 26'h0, 0,   1, 32'h3C, 4, 1));
        tbl.push_back(v(1, 0, 0, 16'h0000, 1, 26'h1, 0,   0, 32'h3C, 4, 1));
        tbl.push_back(v(1, 1, 1, 16'h0003, 0, 26'h0, 1,   0, 32'h3C, 4, 1));
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 26'h0, 0,   0, 32'h00, 0, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 26'h0, 0,   0, 32'h00, 0, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 26'h0, 0,   1, 32'h04, 1, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 26'h0, 1,   1, 32'h08, 2, 1));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 26'h0, 0,   0, 32'h08, 2, 1));
        tbl.push_back(v(0, 1, 0, 16'h0000, 0, 26'h0, 1,   0, 32'h00, 0, 0));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 26'h0, 1,   0, 32'h00, 0, 1));
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 26'h0, 0,   0, 32'h00, 0, 0));

        prev_pc = 32'h0;
        foreach (tbl[k]) begin
            cycle(tbl[k].rst, tbl[k].stall, tbl[k].br, tbl[k].off, tbl[k].jmp, tbl[k].jt,
                  tbl[k].halt, gv, gi);
            model_step(tbl[k].rst, tbl[k].stall, tbl[k].br, tbl[k].off, tbl[k].jmp,
                       tbl[k].jt, tbl[k].halt);
            chk($sformatf("vec%0d instr_valid", k), 32'(gv), 32'(tbl[k].ev));
            chk($sformatf("vec%0d instr", k), gi, tbl[k].ev ? rom[prev_pc[5:2]] : 32'h0);
            chk($sformatf("vec%0d pc", k), bus.pc, tbl[k].epc);
            chk($sformatf("vec%0d pc_plus4", k), bus.pc_plus4, tbl[k].epc + 32'd4);
            chk($sformatf("vec%0d instr_count", k), bus.instr_count, tbl[k].ecnt);
            chk($sformatf("vec%0d halted", k), 32'(bus.halted), 32'(tbl[k].eh));
            prev_pc = tbl[k].epc;
        end

        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(99) >= 4);
            s = ($urandom_range(99) < 25);
            b = ($urandom_range(99) < 25);
            o = ($urandom_range(9) == 0) ? 16'($urandom) : 16'($signed($urandom_range(16)) - 8);
            j = ($urandom_range(99) < 12);
            t = ($urandom_range(9) == 0) ? 26'($urandom) : 26'($urandom_range(17));
            h = ($urandom_range(99) < 3);
            mv = !m_boot && !m_halted;
            mi = mv ? rom[m_pc[5:2]] : 32'h0;
            cycle(r, s, b, o, j, t, h, gv, gi);
            model_step(r, s, b, o, j, t, h);
            chk("rand instr_valid", 32'(gv), 32'(mv));
            chk("rand instr", gi, mi);
            chk("rand pc", bus.pc, m_pc);
            chk("rand pc_plus4", bus.pc_plus4, m_pc + 32'd4);
            chk("rand instr_count", bus.instr_count, m_count);
            chk("rand halted", 32'(bus.halted), 32'(m_halted));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule
